// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock with a registered carry between digits.
// Operands and results move on valid/ready handshakes; one operation in flight at a time.
module digit_serial_addsub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] bq_q, bq_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [DIGIT-1:0] dig_a, dig_b, dig_s;
    logic             dig_c;
    logic             last_dig;

    assign dig_a    = a_q[cnt_q*DIGIT +: DIGIT];
    assign dig_b    = bq_q[cnt_q*DIGIT +: DIGIT];
    assign {dig_c, dig_s} = {1'b0, dig_a} + {1'b0, dig_b} + {{DIGIT{1'b0}}, c_q};
    assign last_dig = (cnt_q == CntW'(NDIG - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        bq_d    = bq_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        c_d     = c_q;
        co_d    = co_q;
        ov_d    = ov_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // Subtraction is folded into addition of ~b with an inverted carry-in.
                    a_d     = a;
                    bq_d    = sub ? ~b : b;
                    c_d     = carryin ^ sub;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d[cnt_q*DIGIT +: DIGIT] = dig_s;
                c_d   = dig_c;
                cnt_d = cnt_q + 1'b1;
                if (last_dig) begin
                    sum_d   = acc_d;
                    co_d    = dig_c;
                    // Carry into the MSB recovered from its sum bit and operand bits.
                    ov_d    = dig_c ^ (dig_s[DIGIT-1] ^ dig_a[DIGIT-1] ^ dig_b[DIGIT-1]);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            bq_q    <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            bq_q    <= bq_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign carryout  = co_q;
    assign overflow  = ov_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Random + directed scoreboard bench for digit_serial_addsub across four WIDTH/DIGIT configurations.
// Drivers push expected results; per-instance monitors pop and compare on each output handshake.
module tb_digit_serial_addsub;

    localparam int NDIR  = 4;
    localparam int NRAND = 1500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit [7:0] dir_a   [NDIR] = '{8'hFF, 8'h7F, 8'h05, 8'h80};
    bit [7:0] dir_b   [NDIR] = '{8'h01, 8'h01, 8'h07, 8'h00};
    bit       dir_cin [NDIR] = '{1'b0, 1'b0, 1'b0, 1'b1};
    bit       dir_sub [NDIR] = '{1'b0, 1'b0, 1'b1, 1'b1};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Plain-integer reference: unsigned result/carry plus signed range test for overflow.
    function automatic void ref_model(input int w, input longint va, input longint vb,
                                      input bit cin, input bit op_sub,
                                      output longint s, output bit co, output bit ov);
        longint lim, half, sa, sb, r, full;
        lim  = longint'(1) << w;
        half = lim / 2;
        sa   = (va >= half) ? va - lim : va;
        sb   = (vb >= half) ? vb - lim : vb;
        if (!op_sub) begin
            full = va + vb + longint'(cin);
            s    = full % lim;
            co   = (full >= lim);
            r    = sa + sb + longint'(cin);
        end else begin
            full = va - vb - longint'(cin);
            s    = (full + lim) % lim;
            co   = (full >= 0);
            r    = sa - sb - longint'(cin);
        end
        ov = (r >= half) || (r < -half);
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int W = (g == 0) ? 8 : 16;
        localparam int D = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 16;
        localparam int N = W / D;

        logic         rst_n, in_valid, in_ready, carryin, sub;
        logic         out_valid, out_ready, carryout, overflow;
        logic [W-1:0] a, b, sum;

        longint q_sum[$];
        bit     q_co[$];
        bit     q_ov[$];
        int     q_acc[$];
        bit     seen = 1'b0;
        bit     fin  = 1'b0;

        digit_serial_addsub #(
            .WIDTH(W),
            .DIGIT(D)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .a        (a),
            .b        (b),
            .carryin  (carryin),
            .sub      (sub),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .sum      (sum),
            .carryout (carryout),
            .overflow (overflow)
        );

        // Monitor: latency on rising out_valid, result contents on handshake.
        always @(negedge clk) begin
            if (rst_n && out_valid && !seen) begin
                if (q_acc.size() == 0) chk("spurious_valid", 64'(out_valid), 64'd0);
                else chk("latency", 64'(cyc - q_acc[0]), 64'(N));
            end
            if (rst_n && out_valid && out_ready) begin
                if (q_sum.size() == 0) begin
                    chk("spurious_result", 64'(out_valid & out_ready), 64'd0);
                end else begin
                    chk("sum", 64'(sum), 64'(q_sum.pop_front()));
                    chk("carryout", 64'(carryout), 64'(q_co.pop_front()));
                    chk("overflow", 64'(overflow), 64'(q_ov.pop_front()));
                    void'(q_acc.pop_front());
                end
            end
            seen = out_valid;
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input bit vc,
                             input bit vs, input int hold, input bit noise);
            longint es;
            bit     eco, eov;
            int     t;
            ref_model(W, longint'(va), longint'(vb), vc, vs, es, eco, eov);
            a = va; b = vb; carryin = vc; sub = vs; in_valid = 1'b1;
            q_sum.push_back(es); q_co.push_back(eco); q_ov.push_back(eov);
            q_acc.push_back(cyc + 1);
            step();
            if (noise) begin
                a = W'($urandom); b = W'($urandom);
                carryin = 1'($urandom); sub = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            t = 0;
            while (!out_valid && t < N + 4) begin
                step();
                t++;
            end
            in_valid = 1'b0;
            chk("valid_timeout", 64'(out_valid), 64'd1);
            for (int h = 0; h < hold; h++) begin
                step();
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_in_ready", 64'(in_ready), 64'd0);
                chk("hold_sum", 64'(sum), 64'(es));
                chk("hold_carryout", 64'(carryout), 64'(eco));
                chk("hold_overflow", 64'(overflow), 64'(eov));
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk("release_valid", 64'(out_valid), 64'd0);
            chk("release_in_ready", 64'(in_ready), 64'd1);
        endtask

        task automatic reset_mid_run();
            a = W'($urandom); b = W'($urandom); carryin = 1'b1; sub = 1'b0; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            repeat ((N > 2) ? 2 : N - 1) step();
            rst_n = 1'b0;
            #1;
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_sum", 64'(sum), 64'd0);
            chk("rst_carryout", 64'(carryout), 64'd0);
            chk("rst_overflow", 64'(overflow), 64'd0);
            step();
            rst_n = 1'b1;
            repeat (N + 2) begin
                step();
                chk("post_rst_valid", 64'(out_valid), 64'd0);
            end
            chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        endtask

        initial begin
            rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
            a = '0; b = '0; carryin = 1'b0; sub = 1'b0;
            #1 rst_n = 1'b0;
            #1;
            chk("reset_in_ready", 64'(in_ready), 64'd1);
            chk("reset_out_valid", 64'(out_valid), 64'd0);
            chk("reset_sum", 64'(sum), 64'd0);
            chk("reset_carryout", 64'(carryout), 64'd0);
            chk("reset_overflow", 64'(overflow), 64'd0);
            step();
            rst_n = 1'b1;
            // Out_ready pulsed outside DONE must have no effect.
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk("idle_out_ready", 64'(out_valid), 64'd0);
            for (int i = 0; i < NDIR + NRAND; i++) begin
                if (i < NDIR) begin
                    issue(W'(dir_a[i]), W'(dir_b[i]), dir_cin[i], dir_sub[i],
                          (i == 0) ? 10 : 1, i == 1);
                end else begin
                    issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                          int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
                end
                if (i == 5) reset_mid_run();
            end
            step();
            chk("queue_drained", 64'(q_sum.size()), 64'd0);
            fin = 1'b1;
        end
    end

    initial begin
        fork
            wait (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin);
            begin
                #(10 * 90000);
                chk("watchdog", 64'(g_cfg[0].fin & g_cfg[1].fin & g_cfg[2].fin & g_cfg[3].fin),
                    64'd1);
            end
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
